// File: rtl/multicycle_cu_if.sv
// Instruction-register fields, ALU flags, memory handshake and datapath
// strobes shared between the multi-cycle control unit and the datapath.
interface multicycle_cu_if #(
    parameter int OP_WIDTH   = 7,
    parameter int CTRL_WIDTH = 4,
    parameter int IMM_WIDTH  = 3
);
    logic [OP_WIDTH-1:0]   Op;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic                  EQ;
    logic                  LT;
    logic                  LTU;
    logic                  mem_ready;
    logic                  mem_req;
    logic                  MemWrite;
    logic                  IorD;
    logic                  IRWrite;
    logic                  PCWrite;
    logic [1:0]            PCsrc;
    logic                  RegWrite;
    logic [1:0]            ResultSrc;
    logic                  ALUsrcA;
    logic                  ALUsrc;
    logic [CTRL_WIDTH-1:0] ALUctrl;
    logic [IMM_WIDTH-1:0]  ImmSrc;

    // Control unit side
    modport master (
        input  Op, funct3, funct7, EQ, LT, LTU, mem_ready,
        output mem_req, MemWrite, IorD, IRWrite, PCWrite, PCsrc,
               RegWrite, ResultSrc, ALUsrcA, ALUsrc, ALUctrl, ImmSrc
    );

    // Datapath / memory side
    modport slave (
        output Op, funct3, funct7, EQ, LT, LTU, mem_ready,
        input  mem_req, MemWrite, IorD, IRWrite, PCWrite, PCsrc,
               RegWrite, ResultSrc, ALUsrcA, ALUsrc, ALUctrl, ImmSrc
    );
endinterface

// File: rtl/multicycle_cu.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXECUTE/MEM/WB sequencer
// driving datapath strobes and a shared instruction/data memory port.
// Optional feature macro: ILLEGAL_TRAP_EN adds a TRAP state and the
// illegal_instr output for unknown opcodes and bad R-type funct7.
module multicycle_cu #(
    parameter int OP_WIDTH   = 7,
    parameter int CTRL_WIDTH = 4,
    parameter int IMM_WIDTH  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    multicycle_cu_if.master  bus
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic             illegal_instr
`endif
);

    localparam logic [OP_WIDTH-1:0] OP_LOAD   = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_IALU   = OP_WIDTH'(19);
    localparam logic [OP_WIDTH-1:0] OP_AUIPC  = OP_WIDTH'(23);
    localparam logic [OP_WIDTH-1:0] OP_STORE  = OP_WIDTH'(35);
    localparam logic [OP_WIDTH-1:0] OP_RALU   = OP_WIDTH'(51);
    localparam logic [OP_WIDTH-1:0] OP_LUI    = OP_WIDTH'(55);
    localparam logic [OP_WIDTH-1:0] OP_BRANCH = OP_WIDTH'(99);
    localparam logic [OP_WIDTH-1:0] OP_JALR   = OP_WIDTH'(103);
    localparam logic [OP_WIDTH-1:0] OP_JAL    = OP_WIDTH'(111);

    localparam logic [CTRL_WIDTH-1:0] ALU_ADD  = CTRL_WIDTH'(0);
    localparam logic [CTRL_WIDTH-1:0] ALU_SUB  = CTRL_WIDTH'(1);
    localparam logic [CTRL_WIDTH-1:0] ALU_SLL  = CTRL_WIDTH'(2);
    localparam logic [CTRL_WIDTH-1:0] ALU_SLT  = CTRL_WIDTH'(3);
    localparam logic [CTRL_WIDTH-1:0] ALU_SLTU = CTRL_WIDTH'(4);
    localparam logic [CTRL_WIDTH-1:0] ALU_XOR  = CTRL_WIDTH'(5);
    localparam logic [CTRL_WIDTH-1:0] ALU_SRL  = CTRL_WIDTH'(6);
    localparam logic [CTRL_WIDTH-1:0] ALU_SRA  = CTRL_WIDTH'(7);
    localparam logic [CTRL_WIDTH-1:0] ALU_OR   = CTRL_WIDTH'(8);
    localparam logic [CTRL_WIDTH-1:0] ALU_AND  = CTRL_WIDTH'(9);

    localparam logic [IMM_WIDTH-1:0] IMM_I = IMM_WIDTH'(0);
    localparam logic [IMM_WIDTH-1:0] IMM_S = IMM_WIDTH'(1);
    localparam logic [IMM_WIDTH-1:0] IMM_B = IMM_WIDTH'(2);
    localparam logic [IMM_WIDTH-1:0] IMM_U = IMM_WIDTH'(3);
    localparam logic [IMM_WIDTH-1:0] IMM_J = IMM_WIDTH'(4);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WB
`ifdef ILLEGAL_TRAP_EN
        ,
        S_TRAP
`endif
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [OP_WIDTH-1:0]   w_op;
    logic [CTRL_WIDTH-1:0] w_alu_r;
    logic [CTRL_WIDTH-1:0] w_alu_i;
    logic [IMM_WIDTH-1:0]  w_imm;
    logic                  w_taken;
    logic                  w_is_store;
`ifdef ILLEGAL_TRAP_EN
    logic                  w_illegal;
`endif

    assign w_op = bus.Op;

    // Instruction-field decode shared by all states
    always_comb begin
        w_alu_r    = ALU_ADD;
        w_taken    = 1'b0;
        w_imm      = IMM_I;
        w_is_store = (w_op == OP_STORE);
        case (bus.funct3)
            3'd0:    w_alu_r = bus.funct7[5] ? ALU_SUB : ALU_ADD;
            3'd1:    w_alu_r = ALU_SLL;
            3'd2:    w_alu_r = ALU_SLT;
            3'd3:    w_alu_r = ALU_SLTU;
            3'd4:    w_alu_r = ALU_XOR;
            3'd5:    w_alu_r = bus.funct7[5] ? ALU_SRA : ALU_SRL;
            3'd6:    w_alu_r = ALU_OR;
            default: w_alu_r = ALU_AND;
        endcase
        // I-type reuses the R-type table; funct3=0 is ADDI, whose imm bit 10 must not select SUB
        w_alu_i = (bus.funct3 == 3'd0) ? ALU_ADD : w_alu_r;
        case (bus.funct3)
            3'd0:    w_taken = bus.EQ;
            3'd1:    w_taken = ~bus.EQ;
            3'd4:    w_taken = bus.LT;
            3'd5:    w_taken = ~bus.LT;
            3'd6:    w_taken = bus.LTU;
            3'd7:    w_taken = ~bus.LTU;
            default: w_taken = 1'b0;
        endcase
        case (w_op)
            OP_STORE:         w_imm = IMM_S;
            OP_BRANCH:        w_imm = IMM_B;
            OP_LUI, OP_AUIPC: w_imm = IMM_U;
            OP_JAL:           w_imm = IMM_J;
            default:          w_imm = IMM_I;
        endcase
`ifdef ILLEGAL_TRAP_EN
        case (w_op)
            OP_LOAD, OP_IALU, OP_AUIPC, OP_STORE, OP_LUI,
            OP_BRANCH, OP_JALR, OP_JAL: w_illegal = 1'b0;
            OP_RALU:  w_illegal = (bus.funct7 != 7'h00) && (bus.funct7 != 7'h20);
            default:  w_illegal = 1'b1;
        endcase
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and Moore strobes; everything forced low while reset is asserted
    always_comb begin
        w_next        = r_state;
        bus.mem_req   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.IorD      = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.PCWrite   = 1'b0;
        bus.PCsrc     = 2'd0;
        bus.RegWrite  = 1'b0;
        bus.ResultSrc = 2'd0;
        bus.ALUsrcA   = 1'b0;
        bus.ALUsrc    = 1'b0;
        bus.ALUctrl   = ALU_ADD;
        bus.ImmSrc    = IMM_I;
`ifdef ILLEGAL_TRAP_EN
        illegal_instr = 1'b0;
`endif
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    bus.mem_req = 1'b1;
                    if (bus.mem_ready) begin
                        bus.IRWrite = 1'b1;
                        bus.PCWrite = 1'b1;
                        w_next      = S_DECODE;
                    end
                end
                S_DECODE: begin
                    bus.ImmSrc = w_imm;
                    w_next     = S_EXECUTE;
                end
                S_EXECUTE: begin
                    bus.ImmSrc = w_imm;
`ifdef ILLEGAL_TRAP_EN
                    if (w_illegal) begin
                        w_next = S_TRAP;
                    end else
`endif
                    begin
                        case (w_op)
                            OP_RALU: begin
                                bus.ALUctrl = w_alu_r;
                                w_next      = S_WB;
                            end
                            OP_IALU: begin
                                bus.ALUsrc  = 1'b1;
                                bus.ALUctrl = w_alu_i;
                                w_next      = S_WB;
                            end
                            OP_LOAD, OP_STORE: begin
                                bus.ALUsrc = 1'b1;
                                w_next     = S_MEM;
                            end
                            OP_BRANCH: begin
                                bus.ALUctrl = ALU_SUB;
                                if (w_taken) begin
                                    bus.PCWrite = 1'b1;
                                    bus.PCsrc   = 2'd1;
                                end
                                w_next = S_FETCH;
                            end
                            OP_JAL: begin
                                bus.PCWrite = 1'b1;
                                bus.PCsrc   = 2'd1;
                                w_next      = S_WB;
                            end
                            OP_JALR: begin
                                bus.ALUsrc  = 1'b1;
                                bus.PCWrite = 1'b1;
                                bus.PCsrc   = 2'd2;
                                w_next      = S_WB;
                            end
                            OP_LUI: begin
                                w_next = S_WB;
                            end
                            OP_AUIPC: begin
                                bus.ALUsrcA = 1'b1;
                                bus.ALUsrc  = 1'b1;
                                w_next      = S_WB;
                            end
                            default: begin
                                w_next = S_FETCH;
                            end
                        endcase
                    end
                end
                S_MEM: begin
                    bus.ImmSrc   = w_imm;
                    bus.mem_req  = 1'b1;
                    bus.IorD     = 1'b1;
                    bus.MemWrite = w_is_store;
                    if (bus.mem_ready) begin
                        w_next = w_is_store ? S_FETCH : S_WB;
                    end
                end
                S_WB: begin
                    bus.ImmSrc   = w_imm;
                    bus.RegWrite = 1'b1;
                    case (w_op)
                        OP_LOAD:         bus.ResultSrc = 2'd1;
                        OP_JAL, OP_JALR: bus.ResultSrc = 2'd2;
                        OP_LUI:          bus.ResultSrc = 2'd3;
                        default:         bus.ResultSrc = 2'd0;
                    endcase
                    w_next = S_FETCH;
                end
`ifdef ILLEGAL_TRAP_EN
                S_TRAP: begin
                    illegal_instr = 1'b1;
                end
`endif
                default: begin
                    w_next = S_FETCH;
                end
            endcase
        end
    end

endmodule
